// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_pkg
// Purpose  : Shared types and constants for the SPI command sequencer:
//            FSM state encoding, opcodes, header field positions, default
//            magic byte and the header validity rule.
// Revision : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_BURST = 8'h02;

    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_OP_MSB    = 23;
    localparam int HDR_OP_LSB    = 16;
    localparam int HDR_ADDR_MSB  = 15;
    localparam int HDR_ADDR_LSB  = 8;
    localparam int HDR_LEN_MSB   = 7;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // A header is usable when the magic byte matches and it is either a
    // single WRITE or a BURST of at least one word.
    function automatic logic hdr_is_valid(input logic [31:0] hdr, input logic [7:0] magic);
        logic [7:0] w_op;
        logic [7:0] w_len;
        w_op  = hdr[HDR_OP_MSB:HDR_OP_LSB];
        w_len = hdr[HDR_LEN_MSB:HDR_LEN_LSB];
        return (hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == magic) &&
               ((w_op == OP_WRITE) || ((w_op == OP_BURST) && (w_len != 8'd0)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_sequencer_if
// Purpose  : Bundles the SPI receive side and the configuration write
//            handshake of the command sequencer. The master modport is the
//            sequencer's view; the slave modport is the surrounding system.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_cmd_sequencer_if;

    logic        spi_en;
    logic [31:0] rx_word;
    logic        rx_rdy;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;

    modport master (
        output spi_en,
        input  rx_word,
        input  rx_rdy,
        output cfg_addr,
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  spi_en,
        output rx_word,
        output rx_rdy,
        input  cfg_addr,
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );

endinterface
`default_nettype wire

// File: rtl/spi_cmd_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_watchdog
// Purpose  : Inter-word timer. Counts clk cycles while run is high, restarts
//            on kick, and flags expired once TIMEOUT_CYC cycles have passed
//            without a kick. Held cleared while run is low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_watchdog #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int C_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [C_CNT_W-1:0] r_cnt;

    // Cycle counter; stops at the limit so expired stays asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (kick || !run) begin
            r_cnt <= '0;
        end else if (!expired) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end
    end

    assign expired = (r_cnt == C_CNT_W'(TIMEOUT_CYC));

endmodule
`default_nettype wire

// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_sequencer
// Purpose  : Decodes SPI command frames (header + data words) into
//            configuration register writes over a valid/ready handshake.
//            Counts completed and aborted frames.
// Options  : SPI_CMD_TIMEOUT_EN - when defined, an inter-word watchdog aborts
//            a frame that stalls for TIMEOUT_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    spi_cmd_sequencer_if.master  bus,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          err_cnt
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_addr;
    logic [7:0]  r_count;
    logic [31:0] r_hold;
    logic        r_overrun;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    logic        w_cfg_valid;
    logic        w_xfer;
    logic        w_expired;
    logic        w_load_hdr;
    logic        w_load_hold;
    logic        w_set_ovr;
    logic        w_frame_inc;
    logic        w_err_inc;

    // Gating with en drops a pending write the moment the sequencer is disabled.
    assign w_cfg_valid = (r_state == ST_ISSUE) && en;
    assign w_xfer      = w_cfg_valid && bus.cfg_ready;

`ifdef SPI_CMD_TIMEOUT_EN
    logic w_wd_run;
    logic w_wd_kick;

    assign w_wd_run  = (r_state == ST_DATA) || (r_state == ST_ISSUE);
    assign w_wd_kick = w_load_hdr || w_load_hold;

    spi_cmd_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (w_wd_run),
        .kick    (w_wd_kick),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        w_state_next = r_state;
        w_load_hdr   = 1'b0;
        w_load_hold  = 1'b0;
        w_set_ovr    = 1'b0;
        w_frame_inc  = 1'b0;
        w_err_inc    = 1'b0;
        if (!en) begin
            w_state_next = ST_IDLE;
        end else if (w_expired && ((r_state == ST_DATA) || (r_state == ST_ISSUE))) begin
            w_state_next = ST_ABORT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_rdy) begin
                        if (hdr_is_valid(bus.rx_word, MAGIC)) begin
                            w_load_hdr   = 1'b1;
                            w_state_next = ST_DATA;
                        end else begin
                            w_state_next = ST_ABORT;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.rx_rdy) begin
                        w_load_hold  = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_xfer) begin
                        if (r_overrun) begin
                            w_state_next = ST_ABORT;
                        end else if (r_count == 8'd1) begin
                            w_frame_inc  = 1'b1;
                            w_state_next = ST_IDLE;
                        end else if (bus.rx_rdy) begin
                            // Next word arriving on the accept cycle is not an overrun.
                            w_load_hold  = 1'b1;
                            w_state_next = ST_ISSUE;
                        end else begin
                            w_state_next = ST_DATA;
                        end
                    end else if (bus.rx_rdy) begin
                        w_set_ovr = 1'b1;
                    end
                end
                ST_ABORT: begin
                    w_err_inc    = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Address, remaining count, hold register, overrun flag and frame counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= 8'd0;
            r_count     <= 8'd0;
            r_hold      <= 32'd0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            if (w_load_hdr) begin
                r_addr  <= bus.rx_word[HDR_ADDR_MSB:HDR_ADDR_LSB];
                r_count <= (bus.rx_word[HDR_OP_MSB:HDR_OP_LSB] == OP_WRITE) ?
                           8'd1 : bus.rx_word[HDR_LEN_MSB:HDR_LEN_LSB];
            end else if (w_xfer) begin
                r_addr  <= r_addr + 8'd1;
                r_count <= r_count - 8'd1;
            end
            if (w_load_hold) begin
                r_hold <= bus.rx_word;
            end
            if (w_state_next != ST_ISSUE) begin
                r_overrun <= 1'b0;
            end else if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign bus.spi_en    = en;
    assign bus.cfg_addr  = r_addr;
    assign bus.cfg_data  = r_hold;
    assign bus.cfg_valid = w_cfg_valid;
    assign busy          = (r_state != ST_IDLE);
    assign frame_cnt     = r_frame_cnt;
    assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire
